pc_fetch_ctrl: RTL and testbench
================================

// Module: pc_fetch_ctrl
// PURPOSE
//  Program-counter and instruction-fetch sequencer for the MIPS core front end.
//  Holds the PC, drives the instruction-memory enable, waits a parametrised fetch latency,
//  then advances to PC+INC or a redirect target when the pipeline is not stalled.
//  Sits between the branch/jump resolution logic and the instruction memory.
// PARAMETERS
//  PC_W       32            PC width in bits
//  RESET_VEC  32'h00400020  PC value loaded on reset
//  TRAP_VEC   32'h80000180  PC loaded on misaligned redirect (PC_MISALIGN_TRAP_EN only)
//  INC        4             sequential PC increment
//  FETCH_WAIT 2             wait cycles after fetch issue before PC may advance (0..15)
//  CNT_W      32            width of fetch_count
// PORTS
//  clk            in   1      clock, rising edge
//  reset          in   1      synchronous reset, active-high
//  en             in   1      advance enable; 0 = stall (hold PC)
//  redirect_valid in   1      branch/jump target valid this cycle
//  redirect_pc    in   PC_W   branch/jump target
//  pc             out  PC_W   current fetch address
//  en_inst_mem    out  1      instruction-memory enable
//  inst_valid     out  1      1-cycle pulse: fetch of inst_pc completed
//  inst_pc        out  PC_W   address of the completed fetch
//  fetch_count    out  CNT_W  completed fetches since reset, wraps at 2^CNT_W
//  misalign_trap  out  1      1-cycle pulse on misaligned redirect (0 without macro)
// BEHAVIOUR
//  Reset (sync, high, any state): pc=RESET_VEC, en_inst_mem=0, inst_valid=0, inst_pc=0,
//   fetch_count=0, misalign_trap=0, pending redirect cleared, state=IDLE, wait cnt=0.
//  FSM: IDLE -> FETCH (1 cycle after reset release, unconditional).
//   FETCH: en_inst_mem=1; -> WAIT (cnt=0), or -> ADVANCE if FETCH_WAIT==0.
//   WAIT: en_inst_mem=1; cnt++; at cnt==FETCH_WAIT-1 -> ADVANCE.
//   ADVANCE: en_inst_mem=1; en=0 -> stay (stall, pc held); en=1 -> FETCH with
//    pc<=next_pc, inst_pc<=old pc, inst_valid<=1 (registered, high the following cycle),
//    fetch_count<=fetch_count+1 (modulo 2^CNT_W).
//  FETCH->next FETCH latency = FETCH_WAIT+2 cycles when en=1 throughout.
//  next_pc priority: redirect_valid this cycle > pending redirect > pc+INC (modulo 2^PC_W).
//  redirect_valid in FETCH/WAIT/stalled ADVANCE (not consumed): latched as pending; newer
//   redirect overwrites older. Pending cleared when consumed. Redirects in IDLE ignored.
//  en is sampled only in ADVANCE; stall never aborts or restarts the wait count.
//  pc+INC wrap: 32'hFFFFFFFC + 4 -> 0, no flag.
// CONFIGURATION
//  PC_MISALIGN_TRAP_EN defined: if consumed target has target[1:0]!=0, pc<=TRAP_VEC,
//   misalign_trap=1 for one cycle (same cycle as inst_valid); inst_valid/fetch_count still update.
//  Undefined: target[1:0] forced to 2'b00; misalign_trap tied 0.
// STRUCTURE
//  Package pc_pkg: state enum {IDLE,FETCH,WAIT,ADVANCE}, ALIGN_MASK constant, default vectors.
//  Sub-module fetch_wait_counter: loadable down/up counter, done flag at FETCH_WAIT-1.
//  Top holds FSM, PC/pending registers, next_pc mux, trap logic.
// TESTING
//  1 reset 3 cycles, release, en=1, FETCH_WAIT=2 -> pc 0x00400020, 0x00400024, 0x00400028 each 4 cycles apart; inst_valid pulses with inst_pc of prior pc.
//  2 en=0 held 5 cycles in ADVANCE -> pc frozen, no inst_valid, fetch_count unchanged; en=1 -> advance next edge.
//  3 redirect_valid=1, redirect_pc=0x00400100 during WAIT, then 0x00400200 next cycle -> next pc 0x00400200.
//  4 redirect in ADVANCE with en=1 and older pending -> same-cycle target wins; pending cleared.
//  5 reset asserted mid-WAIT with pending redirect -> pc=RESET_VEC, en_inst_mem=0, pending dropped.
//  6 redirect_pc=0x00400102: macro on -> pc=TRAP_VEC, misalign_trap 1 cycle; off -> pc=0x00400100.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the PC fetch sequencer.
package pc_pkg;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      WAIT,
      ADVANCE
   } state_t;

   // Low PC bits that must be zero for a word-aligned instruction address
   localparam logic [1:0]  ALIGN_MASK    = 2'b11;
   localparam logic [31:0] DEF_RESET_VEC = 32'h00400020;
   localparam logic [31:0] DEF_TRAP_VEC  = 32'h80000180;

endpackage

// File: rtl/fetch_wait_counter.sv
// Fetch-latency counter: cleared on load, steps while waiting, done at FETCH_WAIT-1.
// Combinational done flag; stepping is controlled entirely by the caller.
module fetch_wait_counter #(
   parameter int FETCH_WAIT = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic step,
   output logic done
);

   localparam logic [3:0] LAST = (FETCH_WAIT > 0) ? 4'(FETCH_WAIT - 1) : 4'd0;

   logic [3:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || load) begin
         cnt <= '0;
      end else if (step) begin
         cnt <= cnt + 4'd1;
      end
   end

   assign done = (cnt == LAST);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC/fetch sequencer: FETCH->next FETCH every FETCH_WAIT+2 cycles; en=0 holds PC in ADVANCE.
// Optional misaligned-redirect trap under `PC_MISALIGN_TRAP_EN (default: target low bits cleared).
module pc_fetch_ctrl
   import pc_pkg::*;
#(
   parameter int              PC_W       = 32,
   parameter logic [PC_W-1:0] RESET_VEC  = DEF_RESET_VEC,
   parameter logic [PC_W-1:0] TRAP_VEC   = DEF_TRAP_VEC,
   parameter int              INC        = 4,
   parameter int              FETCH_WAIT = 2,
   parameter int              CNT_W      = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             redirect_valid,
   input  logic [PC_W-1:0]  redirect_pc,
   output logic [PC_W-1:0]  pc,
   output logic             en_inst_mem,
   output logic             inst_valid,
   output logic [PC_W-1:0]  inst_pc,
   output logic [CNT_W-1:0] fetch_count,
   output logic             misalign_trap
);

   state_t          state, state_nxt;
   logic            cnt_load, cnt_step, cnt_done;
   logic            consume;
   logic            pend_vld;
   logic [PC_W-1:0] pend_pc;
   logic            from_redirect, trap_hit;
   logic [PC_W-1:0] target, target_fix, seq_pc, next_pc;

   fetch_wait_counter #(.FETCH_WAIT(FETCH_WAIT)) u_wait_cnt (
      .clk   (clk),
      .reset (reset),
      .load  (cnt_load),
      .step  (cnt_step),
      .done  (cnt_done)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      cnt_load    = 1'b0;
      cnt_step    = 1'b0;
      consume     = 1'b0;
      en_inst_mem = 1'b1;
      case (state)
         IDLE: begin
            en_inst_mem = 1'b0;
            state_nxt   = FETCH;
         end
         FETCH: begin
            cnt_load  = 1'b1;
            state_nxt = (FETCH_WAIT == 0) ? ADVANCE : WAIT;
         end
         WAIT: begin
            cnt_step = 1'b1;
            if (cnt_done) state_nxt = ADVANCE;
         end
         ADVANCE: begin
            if (en) begin
               consume   = 1'b1;
               state_nxt = FETCH;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // A redirect arriving in the consuming cycle beats any older pending one
   always_comb begin
      from_redirect = redirect_valid || pend_vld;
      target        = redirect_valid ? redirect_pc : pend_pc;
      seq_pc        = pc + PC_W'(INC);
`ifdef PC_MISALIGN_TRAP_EN
      trap_hit      = from_redirect && ((target[1:0] & ALIGN_MASK) != 2'b00);
      target_fix    = target;
`else
      trap_hit      = 1'b0;
      target_fix    = {target[PC_W-1:2], target[1:0] & ~ALIGN_MASK};
`endif
      next_pc       = trap_hit ? TRAP_VEC : (from_redirect ? target_fix : seq_pc);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc            <= RESET_VEC;
         pend_vld      <= 1'b0;
         pend_pc       <= '0;
         inst_valid    <= 1'b0;
         inst_pc       <= '0;
         fetch_count   <= '0;
         misalign_trap <= 1'b0;
      end else begin
         inst_valid    <= consume;
         misalign_trap <= consume && trap_hit;
         if (consume) begin
            pc          <= next_pc;
            inst_pc     <= pc;
            fetch_count <= fetch_count + CNT_W'(1);
            pend_vld    <= 1'b0;
         end else if (redirect_valid && (state != IDLE)) begin
            pend_vld <= 1'b1;
            pend_pc  <= redirect_pc;
         end
      end
   end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Randomized scoreboard bench for pc_fetch_ctrl against a cycle-age reference model.
module tb_pc_fetch_ctrl;

   localparam int          FW = 2;
   localparam logic [31:0] RV = 32'h00400020;
   localparam logic [31:0] TV = 32'h80000180;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] pc, inst_pc, fetch_count;
   logic        en_inst_mem, inst_valid, misalign_trap;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(
      .PC_W(32), .RESET_VEC(RV), .TRAP_VEC(TV), .INC(4), .FETCH_WAIT(FW), .CNT_W(32)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .en             (en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .pc             (pc),
      .en_inst_mem    (en_inst_mem),
      .inst_valid     (inst_valid),
      .inst_pc        (inst_pc),
      .fetch_count    (fetch_count),
      .misalign_trap  (misalign_trap)
   );

   typedef struct {
      logic [31:0] ipc;
      logic [31:0] cnt;
      logic        trap;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: a fetch may complete once it is FW+1 cycles old and en is high.
   bit          m_known = 0;
   bit          m_idle  = 1;
   bit          m_rst   = 0;
   int          m_age   = 0;
   logic [31:0] m_pc    = RV;
   logic [31:0] m_cnt   = '0;
   bit          m_pv    = 0;
   logic [31:0] m_ppc   = '0;

   always @(posedge clk) begin
      logic [31:0] tgt, nxt;
      bit          redir, trap;
      m_rst = 0;
      if (reset) begin
         m_known = 1; m_idle = 1; m_rst = 1;
         m_pc = RV; m_cnt = 0; m_pv = 0; m_age = 0;
         exp_q.delete();
      end else if (m_known) begin
         if (m_idle) begin
            m_idle = 0;
            m_age  = 0;
         end else if (m_age >= FW + 1 && en) begin
            redir = redirect_valid || m_pv;
            tgt   = redirect_valid ? redirect_pc : m_ppc;
            trap  = 0;
`ifdef PC_MISALIGN_TRAP_EN
            if (redir && (tgt % 4) != 0) trap = 1;
`endif
            nxt   = trap ? TV : (redir ? (tgt / 4) * 4 : m_pc + 32'd4);
            m_cnt = m_cnt + 1;
            exp_q.push_back('{ipc: m_pc, cnt: m_cnt, trap: trap});
            m_pc  = nxt;
            m_age = 0;
            m_pv  = 0;
         end else begin
            if (redirect_valid) begin
               m_pv  = 1;
               m_ppc = redirect_pc;
            end
            m_age++;
         end
      end
   end

   // Monitor: per-cycle architectural state plus scoreboard pops on inst_valid
   always @(negedge clk) begin
      if (m_known) begin
         check("pc", pc, m_pc);
         check("en_inst_mem", 32'(en_inst_mem), 32'(!m_idle));
         check("fetch_count", fetch_count, m_cnt);
         if (m_rst) begin
            check("rst_inst_valid", 32'(inst_valid), 32'd0);
            check("rst_inst_pc", inst_pc, 32'd0);
            check("rst_misalign_trap", 32'(misalign_trap), 32'd0);
         end else if (inst_valid) begin
            if (exp_q.size() == 0) begin
               n_cmp++; n_bad++;
               $display("FAIL unexpected_inst_valid: got 1 expected 0 (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check("inst_pc", inst_pc, e.ipc);
               check("valid_fetch_count", fetch_count, e.cnt);
               check("misalign_trap", 32'(misalign_trap), 32'(e.trap));
            end
         end else begin
            check("misalign_trap_quiet", 32'(misalign_trap), 32'd0);
            if (exp_q.size() != 0) begin
               n_cmp++; n_bad++;
               $display("FAIL missing_inst_valid: got 0 expected 1 (t=%0t)", $time);
               exp_q.delete();
            end
         end
      end
   end

   initial begin
      int seg, pick;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk); #1;
         seg   = (i / 250) % 4;
         reset = (i < 3) || ($urandom_range(0, 299) == 0);
         case (seg)
            0:       en = 1'b1;
            1:       en = 1'($urandom_range(0, 1));
            2:       en = ($urandom_range(0, 4) == 0);
            default: en = ($urandom_range(0, 3) != 0);
         endcase
         redirect_valid = (seg != 0) && ($urandom_range(0, 5) == 0);
         pick = $urandom_range(0, 9);
         if (pick == 0)      redirect_pc = 32'hFFFFFFFC;
         else if (pick == 1) redirect_pc = 32'h00400100 | 32'($urandom_range(1, 3));
         else if (pick == 2) redirect_pc = 32'h00400200;
         else                redirect_pc = 32'h00400000 | ($urandom & 32'h00000FFC);
      end
      @(negedge clk); #1;
      reset = 1'b0; en = 1'b1; redirect_valid = 1'b0;
      repeat (12) @(negedge clk);
      #2;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
